// File: rtl/axil_gpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axil_gpio_pkg
//  Purpose  : Shared register offsets, response codes, FSM state types and
//             helpers for the AXI-Lite GPIO register block.
//  Revision : 1.0 - initial release
// ============================================================================
package axil_gpio_pkg;

  // Register word index, decoded from addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;  // 0x0
  localparam logic [1:0] REG_INPUTS = 2'd1;  // 0x4
  localparam logic [1:0] REG_LED    = 2'd2;  // 0x8
  localparam logic [1:0] REG_DUTY   = 2'd3;  // 0xC

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] DUTY_RESET = 8'h80;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  // Select new byte when its write strobe is set, otherwise keep the old one
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/AXIL_IF.sv
`default_nettype none
// ============================================================================
//  Module   : AXIL_IF
//  Purpose  : AXI-Lite bundle (no prot/cache sidebands) with master and
//             slave modports.
//  Revision : 1.0 - initial release
// ============================================================================
interface AXIL_IF #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/gpio_sync.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_sync
//  Purpose  : WIDTH-bit two-flop synchroniser for asynchronous board inputs.
//             Each bit is synchronised independently (no bus coherency).
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Next values: first stage samples the pin, second stage resolves metastability
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, cleared to 0 by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/axil_gpio_regs.sv
`default_nettype none
// ============================================================================
//  Module   : axil_gpio_regs
//  Purpose  : AXI-Lite slave exposing CTRL/INPUTS/LED/DUTY registers for the
//             board switches, buttons and 16 LED lines. Optional global LED
//             brightness PWM, built only when AXIL_GPIO_PWM_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module axil_gpio_regs
  import axil_gpio_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int PWM_PRESCALE = 488
) (
  input  logic        clk,
  input  logic        reset_n,
  AXIL_IF.slave       axil_if,
  input  logic [3:0]  sw,
  input  logic [3:0]  btn,
  output logic [15:0] led
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axil_gpio_regs: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH <= 4) begin : g_bad_addr_width
    $error("axil_gpio_regs: ADDR_WIDTH must exceed 4");
  end
  if (PWM_PRESCALE < 1) begin : g_bad_prescale
    $error("axil_gpio_regs: PWM_PRESCALE must be at least 1");
  end

  wr_state_t   wr_state_q, wr_state_d;
  rd_state_t   rd_state_q, rd_state_d;
  logic        rst_done_q, rst_done_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_reg_q, led_reg_d;
  logic [15:0] led_q, led_d;

  logic        wr_accept, rd_accept;
  logic        wr_unmapped, rd_unmapped;
  logic [1:0]  wr_idx, rd_idx;
  logic [31:0] rd_value;
  logic [7:0]  in_sync;
  logic        pwm_en_view;
  logic [7:0]  duty_view;
  logic        pwm_gate;

  assign wr_idx      = axil_if.awaddr[3:2];
  assign rd_idx      = axil_if.araddr[3:2];
  assign wr_unmapped = |axil_if.awaddr[ADDR_WIDTH-1:4];
  assign rd_unmapped = |axil_if.araddr[ADDR_WIDTH-1:4];

  gpio_sync #(.WIDTH(8)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({btn, sw}),
    .q       (in_sync)
  );

  // Holds every ready low while reset is asserted and for the first edge after
  always_comb begin
    rst_done_d = 1'b1;
  end

  // Write FSM: AW and W are only taken together, one response outstanding at most
  always_comb begin
    wr_state_d = wr_state_q;
    bresp_d    = bresp_q;
    wr_accept  = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (rst_done_q && axil_if.awvalid && axil_if.wvalid) begin
          wr_accept  = 1'b1;
          wr_state_d = WR_RESP;
          bresp_d    = wr_unmapped ? RESP_SLVERR : RESP_OKAY;
        end
      end
      WR_RESP: begin
        if (axil_if.bready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Read FSM: data is snapshotted on the AR handshake and held until R completes
  always_comb begin
    rd_state_d = rd_state_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    rd_accept  = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (rst_done_q && axil_if.arvalid) begin
          rd_accept  = 1'b1;
          rd_state_d = RD_DATA;
          rresp_d    = rd_unmapped ? RESP_SLVERR : RESP_OKAY;
          rdata_d    = rd_value;
        end
      end
      RD_DATA: begin
        if (axil_if.rready) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Read mux from current register values (same-edge writes are not yet visible)
  always_comb begin
    rd_value = '0;
    if (!rd_unmapped) begin
      case (rd_idx)
        REG_CTRL:   rd_value = {31'b0, pwm_en_view};
        REG_INPUTS: rd_value = {24'b0, in_sync};
        REG_LED:    rd_value = {16'b0, led_reg_q};
        REG_DUTY:   rd_value = {24'b0, duty_view};
        default:    rd_value = '0;
      endcase
    end
  end

  // LED register byte-strobed update
  always_comb begin
    led_reg_d = led_reg_q;
    if (wr_accept && !wr_unmapped && (wr_idx == REG_LED)) begin
      led_reg_d = {merge_byte(led_reg_q[15:8], axil_if.wdata[15:8], axil_if.wstrb[1]),
                   merge_byte(led_reg_q[7:0],  axil_if.wdata[7:0],  axil_if.wstrb[0])};
    end
  end

  // Output LED value, gated by the brightness PWM when present
  always_comb begin
    led_d = led_reg_q & {16{pwm_gate}};
  end

`ifdef AXIL_GPIO_PWM_EN
  localparam int PS_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

  logic            ctrl_q, ctrl_d;
  logic [7:0]      duty_q, duty_d;
  logic [PS_W-1:0] prescale_q, prescale_d;
  logic [7:0]      pwm_cnt_q, pwm_cnt_d;

  // CTRL/DUTY register updates and free-running PWM time base
  always_comb begin
    ctrl_d     = ctrl_q;
    duty_d     = duty_q;
    prescale_d = prescale_q + PS_W'(1);
    pwm_cnt_d  = pwm_cnt_q;
    if (prescale_q == PS_W'(PWM_PRESCALE - 1)) begin
      prescale_d = '0;
      pwm_cnt_d  = pwm_cnt_q + 8'd1;
    end
    if (wr_accept && !wr_unmapped) begin
      if ((wr_idx == REG_CTRL) && axil_if.wstrb[0]) ctrl_d = axil_if.wdata[0];
      if (wr_idx == REG_DUTY) duty_d = merge_byte(duty_q, axil_if.wdata[7:0], axil_if.wstrb[0]);
    end
  end

  // PWM state and brightness registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= 1'b0;
      duty_q     <= DUTY_RESET;
      prescale_q <= '0;
      pwm_cnt_q  <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      duty_q     <= duty_d;
      prescale_q <= prescale_d;
      pwm_cnt_q  <= pwm_cnt_d;
    end
  end

  assign pwm_en_view = ctrl_q;
  assign duty_view   = duty_q;
  assign pwm_gate    = !ctrl_q || (pwm_cnt_q < duty_q);
`else
  assign pwm_en_view = 1'b0;
  assign duty_view   = 8'h00;
  assign pwm_gate    = 1'b1;
`endif

  // Bus FSM state, response holding registers, LED register and output stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_done_q <= 1'b0;
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      bresp_q    <= '0;
      rresp_q    <= '0;
      rdata_q    <= '0;
      led_reg_q  <= '0;
      led_q      <= '0;
    end else begin
      rst_done_q <= rst_done_d;
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      led_reg_q  <= led_reg_d;
      led_q      <= led_d;
    end
  end

  assign axil_if.awready = wr_accept;
  assign axil_if.wready  = wr_accept;
  assign axil_if.bvalid  = (wr_state_q == WR_RESP);
  assign axil_if.bresp   = bresp_q;
  assign axil_if.arready = rst_done_q && (rd_state_q == RD_IDLE);
  assign axil_if.rvalid  = (rd_state_q == RD_DATA);
  assign axil_if.rresp   = rresp_q;
  assign axil_if.rdata   = rdata_q;
  assign led             = led_q;

  // Byte lanes and address bits that no register implements
  logic unused_ok;
  assign unused_ok = ^{axil_if.wdata[31:16], axil_if.wstrb[3:2],
                       axil_if.awaddr[1:0], axil_if.araddr[1:0], rd_accept};

endmodule
`default_nettype wire
